// File: rtl/mul_sgn_rr_sched.sv
// mul_sgn_rr_sched: several requesters share one Baugh-Wooley signed multiplier
// through round-robin arbitration and a 2-stage registered pipeline.
//
// Optional feature macro: MUL_SGN_SCHED_PERF_EN adds perf_cnt_o, one 16-bit
// saturating accept counter per requester. The default build has no counters.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A requester holds valid and operands stable until ready. rsp_valid_o is
// driven straight from a register, so it never depends on rsp_ready_i in the
// same cycle.
//
// Ports (mul_sgn_rr_sched):
//   clk_i, rst_ni   clock (rising edge), async active-low reset
//   clear_i         synchronous flush of both pipeline stages
//   req_valid_i     per-requester valid
//   req_ready_o     per-requester accept, one-hot or zero
//   req_x_i/req_y_i packed signed operands, requester k at [k*W +: W]
//   rsp_valid_o     product valid
//   rsp_ready_i     consumer accept
//   rsp_id_o        requester index of the product
//   rsp_p_o         full-width signed product
//   perf_cnt_o      (MUL_SGN_SCHED_PERF_EN only) packed 16-bit accept counters
//
// Ports (mul_sgn): x_i, y_i signed operands; p_o full-width signed product.

module mul_sgn #(
    parameter int WX    = 8,
    parameter int WY    = 8,
    parameter int Speed = 0   // final adder: 0 ripple, 1 Brent-Kung, 2 Sklansky
) (
    input  logic [WX-1:0]    x_i,
    input  logic [WY-1:0]    y_i,
    output logic [WX+WY-1:0] p_o
);
    localparam int W = WX + WY;
    localparam int L = (W > 1) ? $clog2(W) : 1;
    // Correction constant of the modified Baugh-Wooley array.
    localparam logic [W-1:0] BwConst =
        (W'(1) << (W - 1)) + (W'(1) << (WX - 1)) + (W'(1) << (WY - 1));

    logic [W-1:0] sum_v, car_v;

    // Partial-product rows reduced in carry-save form; sign rows are inverted.
    always_comb begin
        logic [W-1:0] row;
        logic [W-1:0] t;
        logic         pp;
        sum_v = BwConst;
        car_v = '0;
        row   = '0;
        t     = '0;
        pp    = 1'b0;
        for (int i = 0; i < WX; i++) begin
            row = '0;
            for (int j = 0; j < WY; j++) begin
                pp = x_i[i] & y_i[j];
                if ((i == WX - 1) != (j == WY - 1)) pp = ~pp;
                row[i+j] = pp;
            end
            t     = sum_v ^ car_v ^ row;
            car_v = ((sum_v & car_v) | (sum_v & row) | (car_v & row)) << 1;
            sum_v = t;
        end
    end

    // Final carry-propagate adder; g ends up holding the carry out of each bit.
    always_comb begin
        logic [W-1:0] g, p, hs;
        logic         c;
        int           j;
        hs = sum_v ^ car_v;
        g  = sum_v & car_v;
        p  = hs;
        c  = 1'b0;
        j  = 0;
        if (Speed == 0) begin
            for (int i = 0; i < W; i++) begin
                c    = g[i] | (p[i] & c);
                g[i] = c;
            end
        end else if (Speed == 1) begin
            for (int l = 0; l < L; l++) begin
                for (int i = 0; i < W; i++) begin
                    if (((i + 1) % (2 << l)) == 0) begin
                        j    = i - (1 << l);
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
            for (int l = L - 2; l >= 0; l--) begin
                for (int i = 0; i < W; i++) begin
                    if (((i + 1) % (2 << l)) == (1 << l) && i >= (2 << l)) begin
                        j    = i - (1 << l);
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
        end else begin
            for (int l = 0; l < L; l++) begin
                for (int i = 0; i < W; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        j    = ((i >> l) << l) - 1;
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
        end
        p_o = hs ^ {g[W-2:0], 1'b0};
    end
endmodule

module mul_sgn_rr_sched #(
    parameter int NumReq = 4,
    parameter int widthX = 8,
    parameter int widthY = 8,
    parameter int speed  = 0,
    localparam int IdW   = $clog2(NumReq)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    input  logic [NumReq*widthX-1:0]   req_x_i,
    input  logic [NumReq*widthY-1:0]   req_y_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [IdW-1:0]             rsp_id_o,
    output logic [widthX+widthY-1:0]   rsp_p_o
`ifdef MUL_SGN_SCHED_PERF_EN
    ,
    output logic [NumReq*16-1:0]       perf_cnt_o
`endif
);
    localparam int PW = widthX + widthY;

    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [widthX-1:0] s1_x_q, s1_x_d;
    logic [widthY-1:0] s1_y_q, s1_y_d;
    logic [IdW-1:0]    s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic [PW-1:0]     s2_p_q, s2_p_d, mul_p;

    logic              s1_rdy, s2_rdy, accept, any_valid;
    logic [IdW-1:0]    gnt_idx;
    logic [NumReq-1:0] grant;
    logic [widthX-1:0] sel_x;
    logic [widthY-1:0] sel_y;

    assign s2_rdy = !s2_valid_q || rsp_ready_i;
    assign s1_rdy = !s1_valid_q || s2_rdy;

    // Lowest valid index at or above rr_ptr wins; failing that, lowest valid overall.
    always_comb begin
        logic           hi_found;
        logic [IdW-1:0] hi_idx, lo_idx;
        hi_found  = 1'b0;
        any_valid = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                any_valid = 1'b1;
                lo_idx    = IdW'(k);
                if (k >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IdW'(k);
                end
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
        grant   = any_valid ? (NumReq'(1) << gnt_idx) : '0;
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_idx == IdW'(k)) begin
                sel_x = req_x_i[k*widthX +: widthX];
                sel_y = req_y_i[k*widthY +: widthY];
            end
        end
    end

    assign req_ready_o = grant & {NumReq{s1_rdy && !clear_i}};
    assign accept      = any_valid && s1_rdy && !clear_i;

    mul_sgn #(.WX(widthX), .WY(widthY), .Speed(speed)) u_mul (
        .x_i(s1_x_q),
        .y_i(s1_y_q),
        .p_o(mul_p)
    );

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_p_d     = s2_p_q;
        if (clear_i) begin
            // Flush: in-flight products vanish, arbitration state is kept.
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_rdy) begin
                s1_valid_d = accept;
                if (accept) begin
                    s1_x_d   = sel_x;
                    s1_y_d   = sel_y;
                    s1_id_d  = gnt_idx;
                    rr_ptr_d = (gnt_idx == IdW'(NumReq - 1)) ? '0 : gnt_idx + IdW'(1);
                end
            end
            if (s2_rdy) begin
                s2_valid_d = s1_valid_q;
                s2_id_d    = s1_id_q;
                s2_p_d     = mul_p;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_p_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_p_q     <= s2_p_d;
        end
    end

    assign rsp_valid_o = s2_valid_q;
    assign rsp_id_o    = s2_id_q;
    assign rsp_p_o     = s2_p_q;

`ifdef MUL_SGN_SCHED_PERF_EN
    for (genvar k = 0; k < NumReq; k++) begin : g_perf
        logic [15:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (req_ready_o[k] && req_valid_i[k] && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) cnt_q <= '0;
            else         cnt_q <= cnt_d;
        end
        assign perf_cnt_o[k*16 +: 16] = cnt_q;
    end
`endif
endmodule
